// File: rtl/lsl_shift_sequencer.sv
// ============================================================================
// Module   : lsl_shift_sequencer
// Brief    : Stage-serial logical-shift-left controller with valid/ready I/O.
//            Optional macro LSL_SEQ_SKIP_EN enables early termination.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lsl_shift_sequencer #(
  parameter int WIDTH  = 4,
  parameter int SWIDTH = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_VALID,
  output logic              I_READY,
  input  logic [WIDTH-1:0]  I,
  input  logic [SWIDTH-1:0] S,
  output logic              O_VALID,
  input  logic              O_READY,
  output logic [WIDTH-1:0]  O,
  output logic              BUSY
);

  localparam int              KW     = (SWIDTH > 1) ? $clog2(SWIDTH) : 1;
  localparam logic [KW-1:0]   C_LAST = KW'(SWIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_acc;
  logic [SWIDTH-1:0] r_amt;
  logic [KW-1:0]     r_k;

  logic [WIDTH-1:0]  w_stage_out;
  logic              w_done;

  always_comb begin
    w_stage_out = r_amt[r_k] ? (r_acc << (1 << r_k)) : r_acc;
`ifdef LSL_SEQ_SKIP_EN
    // Finish as soon as no higher shift-amount bit remains to be applied.
    w_done = 1'b1;
    for (int b = 0; b < SWIDTH; b++) begin
      if ((b > int'(r_k)) && r_amt[b]) begin
        w_done = 1'b0;
      end
    end
`else
    w_done = (r_k == C_LAST);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_amt   <= '0;
      r_k     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (I_VALID) begin
            r_acc <= I;
            r_amt <= S;
            r_k   <= '0;
`ifdef LSL_SEQ_SKIP_EN
            r_state <= (S == '0) ? ST_HOLD : ST_SHIFT;
`else
            r_state <= ST_SHIFT;
`endif
          end
        end
        ST_SHIFT: begin
          r_acc <= w_stage_out;
          r_k   <= r_k + KW'(1);
          if (w_done) begin
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (O_READY) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Ready is masked by reset so that it reads low throughout reset.
  assign I_READY = (r_state == ST_IDLE) && !RESET;
  assign O_VALID = (r_state == ST_HOLD);
  assign BUSY    = (r_state != ST_IDLE);
  assign O       = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_lsl_shift_sequencer.sv
// ============================================================================
// Module   : tb_lsl_shift_sequencer
// Brief    : Directed scoreboard bench for lsl_shift_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lsl_shift_sequencer;

  logic       CLK     = 1'b0;
  logic       RESET   = 1'b1;
  logic       I_VALID = 1'b0;
  logic       O_READY = 1'b0;
  logic [3:0] I       = 4'd0;
  logic [1:0] S       = 2'd0;
  logic       I_READY;
  logic       O_VALID;
  logic [3:0] O;
  logic       BUSY;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] exp_q[$];

  always #5 CLK = ~CLK;

  lsl_shift_sequencer #(.WIDTH(4), .SWIDTH(2)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .I_VALID (I_VALID),
    .I_READY (I_READY),
    .I       (I),
    .S       (S),
    .O_VALID (O_VALID),
    .O_READY (O_READY),
    .O       (O),
    .BUSY    (BUSY)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int exp_lat(input logic [1:0] s);
`ifdef LSL_SEQ_SKIP_EN
    if (s == 2'd0) return 1;
    else if (s[1]) return 3;
    else return 2;
`else
    return 3;
`endif
  endfunction

  function automatic logic [3:0] model(input logic [3:0] d, input logic [1:0] s);
    logic [3:0] r;
    r = d << s;
    return r;
  endfunction

  // Issue one request, wait for its result, optionally stall, then consume it.
  task automatic req(input logic [3:0] d, input logic [1:0] s, input logic [3:0] exp_o,
                     input int stall, input string tag);
    int         lat;
    logic [3:0] want;
    check({tag, " ready_idle"}, I_READY, 1);
    I = d; S = s; I_VALID = 1'b1;
    exp_q.push_back(exp_o);
    tick();
    I_VALID = 1'b0; I = ~d; S = ~s;
    lat = 1;
    while (O_VALID !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat(s));
    check({tag, " busy_hold"}, BUSY, 1);
    if (exp_q.size() == 0) begin
      check({tag, " queue_empty"}, 1, 0);
      want = 4'd0;
    end else begin
      want = exp_q.pop_front();
    end
    check({tag, " result"}, O, want);
    for (int c = 0; c < stall; c++) begin
      I_VALID = 1'b1;
      tick();
      check({tag, " stall_valid"}, O_VALID, 1);
      check({tag, " stall_o"}, O, want);
      check({tag, " stall_ready"}, I_READY, 0);
    end
    I_VALID = 1'b0;
    check({tag, " ready_in_consume"}, I_READY, 0);
    O_READY = 1'b1;
    tick();
    O_READY = 1'b0;
    check({tag, " valid_after"}, O_VALID, 0);
    check({tag, " busy_after"}, BUSY, 0);
    check({tag, " ready_after"}, I_READY, 1);
  endtask

  initial begin
    // Reset held for two cycles
    RESET = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst O", O, 0);
      check("rst O_VALID", O_VALID, 0);
      check("rst BUSY", BUSY, 0);
      check("rst I_READY", I_READY, 0);
    end
    RESET = 1'b0;
    #1;
    check("post_rst I_READY", I_READY, 1);

    req(4'b1011, 2'd1, 4'b0110, 0, "basic");

    // Back-to-back
    req(4'b0001, 2'd3, 4'b1000, 0, "b2b_a");
    req(4'b1111, 2'd2, 4'b1100, 0, "b2b_b");

    // Backpressure
    req(4'b0101, 2'd2, 4'b0100, 5, "bp");

    // Reset during SHIFT discards the request
    check("mid_rst ready", I_READY, 1);
    I = 4'b0011; S = 2'd1; I_VALID = 1'b1;
    tick();
    I_VALID = 1'b0;
    check("mid_rst busy", BUSY, 1);
    RESET = 1'b1;
    tick();
    check("mid_rst O", O, 0);
    check("mid_rst O_VALID", O_VALID, 0);
    check("mid_rst BUSY", BUSY, 0);
    RESET = 1'b0;
    #1;
    check("mid_rst ready_after", I_READY, 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("mid_rst no_valid", O_VALID, 0);
    end

    // Latency across every shift amount
    req(4'b1001, 2'd0, 4'b1001, 0, "s0");
    req(4'b1001, 2'd1, 4'b0010, 0, "s1");
    req(4'b1001, 2'd2, 4'b0100, 0, "s2");
    req(4'b1001, 2'd3, 4'b1000, 1, "s3");

    // Random vectors against the flat reference shifter
    for (int n = 0; n < 8; n++) begin
      logic [3:0] d;
      logic [1:0] s;
      d = 4'($urandom_range(0, 15));
      s = 2'($urandom_range(0, 3));
      req(d, s, model(d, s), n % 3, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
